// File: rtl/pusch_symbol_buffer_nbank_if.sv
// Mapper write port, commit strobe and FFT read stream of the N-bank symbol buffer.
// Read handshake: a sample moves on a CLK rising edge when rd_valid && rd_ready; while
// rd_valid=1 and rd_ready=0 the buffer holds rd_valid, rd_data, rd_sop and rd_eop unchanged,
// and rd_valid is never withdrawn before the sample has been taken.
interface pusch_symbol_buffer_nbank_if #(
    parameter int DATA_WIDTH = 18,
    parameter int ADDR_WIDTH = 11
);
    logic                  wr_valid;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  commit;
    logic [ADDR_WIDTH-1:0] commit_len;
    logic                  rd_ready;
    logic                  rd_valid;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_sop;
    logic                  rd_eop;
    logic                  full;
    logic                  empty;
    logic [ADDR_WIDTH-1:0] banks_used;
    logic                  overflow_err;
    logic                  len_err;
    logic                  rd_state_dbg;

    modport slave (
        input  wr_valid, wr_addr, wr_data, commit, commit_len, rd_ready,
        output rd_valid, rd_data, rd_sop, rd_eop, full, empty, banks_used,
               overflow_err, len_err, rd_state_dbg
    );

    modport master (
        output wr_valid, wr_addr, wr_data, commit, commit_len, rd_ready,
        input  rd_valid, rd_data, rd_sop, rd_eop, full, empty, banks_used,
               overflow_err, len_err, rd_state_dbg
    );
endinterface

// File: rtl/pusch_symbol_buffer_nbank.sv
// N-bank symbol buffer between the modulation mapper and the FFT.
// The writer fills one bank, commits it with a length, and committed banks drain in FIFO
// order as a sop/eop framed stream. Entries never written in a bank read back as zero.
module pusch_symbol_buffer_nbank #(
    parameter int NUM_BANKS  = 2,
    parameter int MEM_DEPTH  = 1200,
    parameter int DATA_WIDTH = 18,
    parameter int ADDR_WIDTH = 11
) (
    input  logic                        CLK,
    input  logic                        RST,
    pusch_symbol_buffer_nbank_if.slave  bus
);
    localparam int BANK_W    = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
    localparam int RAM_WORDS = NUM_BANKS * MEM_DEPTH;
    localparam int RAM_AW    = $clog2(RAM_WORDS);
    localparam logic [ADDR_WIDTH-1:0] DEPTH_A = ADDR_WIDTH'(MEM_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] NB_A    = ADDR_WIDTH'(NUM_BANKS);
    localparam logic [ADDR_WIDTH-1:0] ONE_A   = ADDR_WIDTH'(1);

    typedef enum logic {
        RD_IDLE   = 1'b0,
        RD_STREAM = 1'b1
    } rd_state_t;

    function automatic logic [BANK_W-1:0] next_bank(input logic [BANK_W-1:0] b);
        return (b == BANK_W'(NUM_BANKS - 1)) ? '0 : b + BANK_W'(1);
    endfunction

    // Storage
    logic [DATA_WIDTH-1:0] mem [RAM_WORDS];
    logic [MEM_DEPTH-1:0]  written [NUM_BANKS];
    logic [ADDR_WIDTH-1:0] bank_len [NUM_BANKS];
    logic [DATA_WIDTH-1:0] ram_q;

    // Bank bookkeeping: writer bank, bank being issued to the pipeline, oldest unreleased bank
    logic [BANK_W-1:0]     wr_bank, iss_bank, rel_bank;
    logic [ADDR_WIDTH-1:0] iss_addr;
    logic [ADDR_WIDTH-1:0] banks_used;
    logic [ADDR_WIDTH-1:0] n_issue;
    rd_state_t             rd_state;
    logic                  ovf_q, len_q;

    // Read pipeline: stage 1 holds the RAM/bitmap read, stage 2 is the output register
    logic                  s1_valid, s1_sop, s1_eop, s1_bit;
    logic                  out_valid, out_sop, out_eop;
    logic [DATA_WIDTH-1:0] out_data;

    logic                  full_w, wr_accept, commit_accept, adv, can_issue, iss_last;
    logic                  iss_done, release_now;
    logic [ADDR_WIDTH-1:0] wr_idx, iss_idx, commit_len_c;
    logic [RAM_AW-1:0]     wr_ram_addr, rd_ram_addr;

    assign full_w        = (banks_used == NB_A);
    assign wr_idx        = bus.wr_addr - ONE_A;
    assign iss_idx       = iss_addr - ONE_A;
    assign commit_len_c  = (bus.commit_len > DEPTH_A) ? DEPTH_A : bus.commit_len;
    assign wr_accept     = bus.wr_valid && (bus.wr_addr != '0) && (bus.wr_addr <= DEPTH_A) && !full_w;
    assign commit_accept = bus.commit && (bus.commit_len != '0) && !full_w;
    // The whole pipeline advances unless the output register holds an untaken sample
    assign adv           = !out_valid || bus.rd_ready;
    // n_issue counts committed banks whose samples are not all issued yet
    assign can_issue     = (n_issue != '0) && adv;
    assign iss_last      = (iss_addr == bank_len[iss_bank]);
    assign iss_done      = can_issue && iss_last;
    assign release_now   = out_valid && out_eop && bus.rd_ready;
    assign wr_ram_addr   = RAM_AW'(int'(wr_bank) * MEM_DEPTH + int'(wr_idx));
    assign rd_ram_addr   = RAM_AW'(int'(iss_bank) * MEM_DEPTH + int'(iss_idx));

    // Sample RAM: mapper write port and a read port enabled only when the pipeline advances
    always_ff @(posedge CLK) begin
        if (wr_accept) begin
            mem[wr_ram_addr] <= bus.wr_data;
        end
        if (can_issue) begin
            ram_q <= mem[rd_ram_addr];
        end
    end

    // Written bitmaps: set by accepted writes, wiped when the bank is released
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int b = 0; b < NUM_BANKS; b++) begin
                written[b] <= '0;
            end
        end else begin
            if (release_now) begin
                written[rel_bank] <= '0;
            end
            if (wr_accept) begin
                written[wr_bank][wr_idx] <= 1'b1;
            end
        end
    end

    // Bank queue, read FSM and sticky error flags
    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_bank    <= '0;
            iss_bank   <= '0;
            rel_bank   <= '0;
            iss_addr   <= ONE_A;
            banks_used <= '0;
            n_issue    <= '0;
            rd_state   <= RD_IDLE;
            ovf_q      <= 1'b0;
            len_q      <= 1'b0;
            for (int b = 0; b < NUM_BANKS; b++) begin
                bank_len[b] <= '0;
            end
        end else begin
            if (commit_accept) begin
                bank_len[wr_bank] <= commit_len_c;
                wr_bank           <= next_bank(wr_bank);
            end
            if (release_now) begin
                rel_bank <= next_bank(rel_bank);
            end

            case ({commit_accept, release_now})
                2'b10:   banks_used <= banks_used + ONE_A;
                2'b01:   banks_used <= banks_used - ONE_A;
                default: ;
            endcase

            case ({commit_accept, iss_done})
                2'b10:   n_issue <= n_issue + ONE_A;
                2'b01:   n_issue <= n_issue - ONE_A;
                default: ;
            endcase

            if (can_issue) begin
                if (iss_last) begin
                    iss_addr <= ONE_A;
                    iss_bank <= next_bank(iss_bank);
                end else begin
                    iss_addr <= iss_addr + ONE_A;
                end
            end

            case (rd_state)
                RD_IDLE: begin
                    if (n_issue != '0) begin
                        rd_state <= RD_STREAM;
                    end
                end
                RD_STREAM: begin
                    if ((n_issue == '0) && !s1_valid && !out_valid) begin
                        rd_state <= RD_IDLE;
                    end
                end
                default: rd_state <= RD_IDLE;
            endcase

            if ((bus.wr_valid || bus.commit) && full_w) begin
                ovf_q <= 1'b1;
            end
            if (bus.commit && (bus.commit_len == '0) && !full_w) begin
                len_q <= 1'b1;
            end
        end
    end

    // Two-stage read pipeline; both stages freeze while the output sample waits for rd_ready
    always_ff @(posedge CLK) begin
        if (RST) begin
            s1_valid  <= 1'b0;
            s1_sop    <= 1'b0;
            s1_eop    <= 1'b0;
            s1_bit    <= 1'b0;
            out_valid <= 1'b0;
            out_sop   <= 1'b0;
            out_eop   <= 1'b0;
            out_data  <= '0;
        end else if (adv) begin
            s1_valid  <= can_issue;
            s1_sop    <= (iss_addr == ONE_A);
            s1_eop    <= iss_last;
            s1_bit    <= written[iss_bank][iss_idx];
            out_valid <= s1_valid;
            out_sop   <= s1_valid && s1_sop;
            out_eop   <= s1_valid && s1_eop;
            out_data  <= s1_bit ? ram_q : '0;
        end
    end

    assign bus.rd_valid     = out_valid;
    assign bus.rd_data      = out_data;
    assign bus.rd_sop       = out_sop;
    assign bus.rd_eop       = out_eop;
    assign bus.full         = full_w;
    assign bus.empty        = (banks_used == '0);
    assign bus.banks_used   = banks_used;
    assign bus.overflow_err = ovf_q;
    assign bus.len_err      = len_q;
    assign bus.rd_state_dbg = rd_state;
endmodule

// File: doc/pusch_symbol_buffer_nbank.md
Name: pusch_symbol_buffer_nbank

Overview:
- Parametrised N-bank successor of the mapper-to-FFT ping-pong memory.
- The modulation mapper writes one OFDM symbol of mapped I/Q samples into the writer-owned bank, then commits it with its length.
- Committed banks queue in FIFO order. Each one drains to the FFT as a valid/ready stream framed by sop/eop, then returns to the free pool.
- Unlike the two-bank version, it supports any bank count, an explicit full/overflow indication, per-entry zero-fill of unwritten samples, and back-pressure on every output sample.

Parameters:
- NUM_BANKS, 2, number of symbol banks (>=2).
- MEM_DEPTH, 1200, samples per bank (max subcarriers).
- DATA_WIDTH, 18, I/Q sample width.
- ADDR_WIDTH, 11, address/length width; must satisfy 2^ADDR_WIDTH > MEM_DEPTH.

Ports:
- CLK  in  1  single clock for all logic.
- RST  in  1  synchronous, active-high reset, sampled on the CLK rising edge.
- wr_valid  in  1  write strobe from mapper.
- wr_addr  in  ADDR_WIDTH  1-based sample index (1..MEM_DEPTH).
- wr_data  in  DATA_WIDTH  sample.
- commit  in  1  one-cycle pulse: the current write bank is complete.
- commit_len  in  ADDR_WIDTH  symbol length to read back, sampled with commit.
- rd_ready  in  1  FFT can accept a sample (inverse of BUSY).
- rd_valid  out  1  rd_data valid.
- rd_data  out  DATA_WIDTH  output sample.
- rd_sop  out  1  first sample of symbol.
- rd_eop  out  1  last sample of symbol.
- full  out  1  no free bank for the writer.
- empty  out  1  no committed bank pending or being read.
- banks_used  out  ADDR_WIDTH  committed-unreleased bank count (0..NUM_BANKS).
- overflow_err  out  1  sticky: write or commit dropped because the buffer was full.
- len_err  out  1  sticky: commit_len was 0.

Behaviour:
- Reset: all outputs 0 except empty=1. Writer owns bank 0, read queue empty, all per-entry written bits cleared. RAM contents need not be cleared.
- Each bank carries a written bitmap of MEM_DEPTH bits.
  - A write sets the entry's bit.
  - Reading an entry whose bit is clear returns 0.
  - A bank's bitmap is cleared on its release.
- Write rules:
  - Accepted when wr_valid=1, 1<=wr_addr<=MEM_DEPTH and full=0; stored at entry wr_addr-1 of the writer bank.
  - Out-of-range address: dropped silently.
  - wr_valid while full=1: dropped, overflow_err set.
- Commit rules:
  - commit_len is clamped to MEM_DEPTH.
  - A write in the same cycle as commit belongs to the committing bank.
  - The bank is pushed to the read queue with its length, and banks_used increments.
  - The writer then moves to the next bank in round-robin order.
  - full = (banks_used == NUM_BANKS).
  - commit with commit_len=0: ignored, len_err set.
  - commit while full: dropped, overflow_err set, even if a release occurs in the same cycle.
- Read FSM, states IDLE / STREAM:
  - IDLE -> STREAM when the queue is non-empty.
  - The read address starts at 1. First rd_valid is asserted exactly 2 cycles after the cycle a commit is accepted into an empty, idle buffer (synchronous RAM read + output register).
  - A transfer occurs when rd_valid && rd_ready.
  - rd_ready=0 freezes rd_valid, rd_data, rd_sop and rd_eop, and stalls the read address.
  - Samples are streamed gap-free while rd_ready=1.
  - rd_sop accompanies address 1; rd_eop accompanies address = bank length. Both are set for length 1.
- Release and bank switching:
  - On the eop transfer the bank is released, banks_used decrements and its bitmap is cleared.
  - If another bank is queued, its sop sample follows on the next cycle with no bubble (prefetch); otherwise the FSM returns to IDLE and rd_valid drops.
- Simultaneous commit and release: banks_used is unchanged, and full is evaluated after both.
- Wrap-around: bank indices and queue pointers wrap modulo NUM_BANKS; order is strictly FIFO.
- Reset mid-operation: the in-flight stream is aborted; state returns to reset values in the cycle after RST is seen.

Test Plan:
- NUM_BANKS=2, write addrs 1..12 with data=addr, commit len=12, rd_ready=1 -> rd_valid 2 cycles after commit; data 1..12; sop on 1, eop on 12; banks_used 1->0, empty=1.
- Write only addrs 1,3,5 and commit len=6 -> output 1,0,3,0,5,0.
- Commit 3 symbols (len 4) with NUM_BANKS=3 while rd_ready=0 -> full=1. A 4th write sets overflow_err with no data corruption. Releasing rd_ready gives 12 back-to-back samples with no bubble between eop/sop.
- Toggle rd_ready every other cycle during a len-8 read -> exactly 8 transfers in order; outputs stable while rd_ready=0.
- commit_len=0 -> len_err=1, no bank advance. commit_len=1500 -> reads 1200 samples.
- Assert RST for one cycle mid-stream -> next cycle rd_valid=0, empty=1, banks_used=0. The next symbol reads zeros in unwritten entries.
